// File: rtl/sail_div_pkg.sv
// sail_div_pkg: shared definitions for the RV32M divider (dsp_div32).
//   - op encodings (funct3[1:0]) for DIV/DIVU/REM/REMU
//   - divider FSM state type
//   - iteration count and divide-by-zero quotient constant
//   - neg_if(): conditional two's-complement negation
package sail_div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } div_state_e;

  localparam int unsigned DIV_ITERATIONS = 32;
  localparam logic [31:0] DIV0_QUOTIENT  = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/dsp_sub32.sv
// dsp_sub32: purely combinational 32-bit subtractor, diff = a - b.
// Written so it maps onto one SB_MAC16 in adder/subtractor bypass mode
// (ADDSUB tied high, no input/output registers).
//   a_i      [31:0] minuend
//   b_i      [31:0] subtrahend
//   diff_o   [31:0] a - b (mod 2^32)
//   borrow_o        1 when b > a (unsigned)
module dsp_sub32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] diff_o,
  output logic        borrow_o
);

  logic [32:0] full;

  assign full     = {1'b0, a_i} - {1'b0, b_i};
  assign diff_o   = full[31:0];
  assign borrow_o = full[32];

endmodule

// File: rtl/dsp_div32.sv
// dsp_div32: multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per clock; trial subtraction in dsp_sub32.
//   clk, rst (async, active-high)
//   start          request, sampled only in IDLE
//   op[1:0]        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend[31:0] rs1, divisor[31:0] rs2 (captured on accepted start)
//   busy           high from the accepting edge through DONE
//   done           one-cycle pulse; result valid with it
//   result[31:0]   quotient (op[1]=0) or remainder (op[1]=1), held
// Build option: define DSP_DIV32_SIGNED_EN for signed DIV/REM semantics;
// otherwise op[0] is ignored and every operation is unsigned.
module dsp_div32
  import sail_div_pkg::*;
#(
  parameter int unsigned ITERATIONS = DIV_ITERATIONS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned         CNT_W    = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(ITERATIONS - 1);

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              op_rem_q;
  logic [31:0]       dvsr_q;
  logic [31:0]       quo_q;
  logic [31:0]       rem_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       result_q;

  logic              a_neg, b_neg, div0, ovf;
  logic [31:0]       a_mag, b_mag, special_d;
  logic [31:0]       s_lo, t_diff, rem_d, quo_d, fix_q, fix_r;
  logic              borrow, sub_ok;

  // Operand sign handling at capture time.
`ifdef DSP_DIV32_SIGNED_EN
  assign a_neg = ~op[0] & dividend[31];
  assign b_neg = ~op[0] & divisor[31];
  assign ovf   = ~op[0] & (dividend == 32'h8000_0000) & (divisor == '1);
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign ovf   = 1'b0;
`endif

  assign a_mag = neg_if(a_neg, dividend);
  assign b_mag = neg_if(b_neg, divisor);
  assign div0  = (divisor == '0);

  // Results for the cases that skip the iteration loop.
  always_comb begin
    special_d = '0;
    if (div0)
      special_d = op[1] ? dividend : DIV0_QUOTIENT;
    else
      special_d = op[1] ? 32'h0000_0000 : 32'h8000_0000;
  end

  // S = {R, Q[31]}: S[32] is rem_q[31], S[31:0] is s_lo.
  assign s_lo = {rem_q[30:0], quo_q[31]};

  dsp_sub32 u_sub (
    .a_i      (s_lo),
    .b_i      (dvsr_q),
    .diff_o   (t_diff),
    .borrow_o (borrow)
  );

  // A set S[32] means S >= 2^32 > divisor, so the trial always succeeds.
  assign sub_ok = rem_q[31] | ~borrow;
  assign rem_d  = sub_ok ? t_diff : s_lo;
  assign quo_d  = {quo_q[30:0], sub_ok};

  assign fix_q = neg_if(q_neg_q, quo_q);
  assign fix_r = neg_if(r_neg_q, rem_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_rem_q <= 1'b0;
      dvsr_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_rem_q <= op[1];
            dvsr_q   <= b_mag;
            quo_q    <= a_mag;
            rem_q    <= '0;
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            cnt_q    <= CNT_LOAD;
            busy_q   <= 1'b1;
            if (div0 || ovf) begin
              result_q <= special_d;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              state_q  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0)
            state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= op_rem_q ? fix_r : fix_q;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_dsp_div32.sv
// Self-checking bench for dsp_div32: directed cases plus random operands
// against a plain-arithmetic reference; a monitor compares against a queue
// of expected results and completion cycles.
module tb_dsp_div32;
  import sail_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] result;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  logic [31:0] held = '0;

  logic [31:0] exp_res_q[$];
  int unsigned exp_cyc_q[$];
  string       exp_tag_q[$];

  dsp_div32 #(.ITERATIONS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic flush_sb();
    exp_res_q.delete();
    exp_cyc_q.delete();
    exp_tag_q.delete();
  endtask

  // Reference: RV32M division rules in plain arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int unsigned lat);
    logic [31:0] q, r;
    bit sgn;
    int sa, sb;
`ifdef DSP_DIV32_SIGNED_EN
    sgn = !o[0];
`else
    sgn = 1'b0;
`endif
    lat = 34;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    res = o[1] ? r : q;
  endfunction

  // Monitor: pops one expectation per done pulse; result must not move otherwise.
  initial begin
    logic [31:0] e;
    int unsigned c;
    string t;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got result %08h with no pending operation", result);
        end else begin
          e = exp_res_q.pop_front();
          c = exp_cyc_q.pop_front();
          t = exp_tag_q.pop_front();
          check({t, " result"}, result, e);
          check({t, " latency"}, cyc, c);
          held = e;
        end
      end else begin
        check("result_hold", result, held);
      end
    end
  end

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int unsigned lat,
                        input int poke_at, input int rst_at, input bit hold);
    int n;
    bit bad;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    exp_res_q.push_back(er);
    exp_cyc_q.push_back(cyc + lat);
    exp_tag_q.push_back(tag);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
    n = 0; bad = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) bad = 1'b1;
      if (n == poke_at) begin
        start = 1'b1; op = 2'($urandom); dividend = $urandom; divisor = $urandom | 32'd1;
      end
      if (n == poke_at + 1) start = 1'b0;
      if (n == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check({tag, " rst_busy"}, 32'(busy), 32'd0);
        check({tag, " rst_done"}, 32'(done), 32'd0);
        check({tag, " rst_result"}, result, 32'd0);
        flush_sb();
        held = '0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: done not seen within 100 cycles, got busy=%0b", tag, busy);
      flush_sb();
      return;
    end
    if (busy !== 1'b1) bad = 1'b1;
    check({tag, " busy_hold"}, 32'(bad), 32'd0);
    if (hold) begin
      start = 1'b1; op = o; dividend = a; divisor = b;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, rr;
    int unsigned rl;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, -1, -1, 1'b1);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34, -1, -1, 1'b0);
    run_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, -1, -1, 1'b1);
    run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5, 1, -1, -1, 1'b0);
    run_op("div_m5_0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, -1, -1, 1'b0);
    run_op("rem_m5_0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, -1, -1, 1'b0);
`ifdef DSP_DIV32_SIGNED_EN
    run_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, -1, -1, 1'b0);
    run_op("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, -1, -1, 1'b0);
    run_op("div_ovf",    OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1, -1, 1'b0);
    run_op("rem_ovf",    OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, -1, -1, 1'b0);
`else
    run_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 34, -1, -1, 1'b0);
    run_op("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'd2, 34, -1, -1, 1'b0);
    run_op("div_ovf",    OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, -1, -1, 1'b0);
    run_op("rem_ovf",    OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, -1, -1, 1'b0);
`endif
    run_op("busy_poke",  OP_DIVU, 32'd1000, 32'd7, 32'd142, 34, 10, -1, 1'b0);
    run_op("rst_mid",    OP_DIVU, 32'd123456789, 32'd17, 32'd7262164, 34, -1, 20, 1'b0);
    run_op("after_rst",  OP_DIVU, 32'd9, 32'd3, 32'd3, 34, -1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 1000);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, rr, rl);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, rr, rl, -1, -1, i[0]);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_res_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
